// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: feeder for the iterative integer square-root core.
// Buffers radicands in a small FIFO and issues them one at a time with a
// single-cycle start pulse. Captures each core result into a one-entry
// output slot, in order. A watchdog flags a core that never completes.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_rad       radicand producer (valid/ready)
//   out_valid/out_ready            result consumer (valid/ready)
//   out_rad/out_root/out_rem       {radicand, floor(sqrt), remainder}
//   core_start/core_rad            issue to the core (start is one cycle)
//   core_busy/core_valid           core status, sampled only in WAIT_DONE
//   core_root/core_rem             core result
//   level                          FIFO occupancy
//   err                            sticky watchdog error
module sqrt_dispatch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ITER  = WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_rad,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_rad,
  output logic [WIDTH-1:0]         out_root,
  output logic [WIDTH-1:0]         out_rem,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_rad,
  input  logic                     core_busy,
  input  logic                     core_valid,
  input  logic [WIDTH-1:0]         core_root,
  input  logic [WIDTH-1:0]         core_rem,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned LW       = PW + 1;
  localparam int unsigned WD_LIMIT = ITER + 4;
  localparam int unsigned CW       = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     wd_q;
  logic              push;
  logic              issue;
  logic              done;
  logic              capture;

  // Full flag decoded straight from the occupancy register.
  assign in_ready = (level != LW'(DEPTH));

  // Handshake decode and next-state logic.
  always_comb begin
    push    = in_valid && in_ready;
    // Core status is qualified by state so stale/unknown values are ignored.
    done    = (state_q == WAIT_DONE) && !core_busy && core_valid;
    capture = done && (!out_valid || out_ready);
    issue   = ((state_q == IDLE) || capture) && (level != '0);
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (capture) state_d = issue ? ISSUE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_rad;
  end

  // State, pointers, issue/capture registers and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      core_start <= 1'b0;
      core_rad   <= '0;
      out_valid  <= 1'b0;
      out_rad    <= '0;
      out_root   <= '0;
      out_rem    <= '0;
      wd_q       <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= issue;
      level      <= level + LW'(push) - LW'(issue);
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) begin
        rd_ptr   <= rd_ptr + PW'(1);
        core_rad <= mem[rd_ptr];
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_rad   <= core_rad;
        out_root  <= core_root;
        out_rem   <= core_rem;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Counts only cycles where the core itself is late, not slot stalls.
      if (state_q == ISSUE) begin
        wd_q <= '0;
      end else if ((state_q == WAIT_DONE) && !done && (wd_q != CW'(WD_LIMIT))) begin
        wd_q <= wd_q + CW'(1);
      end
      if ((state_q == WAIT_DONE) && !done && (wd_q == CW'(WD_LIMIT - 1))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sqrt_dispatch.md
Name: sqrt_dispatch

Overview:
- Upstream feeder for the iterative integer square-root core.
- Buffers radicands from a valid/ready producer in a small FIFO and issues them to the core one at a time with a single-cycle start pulse.
- Captures root/remainder when the core finishes and presents {radicand, root, remainder} on a valid/ready result port, in order.
- Includes a watchdog that flags a core that never completes.

Parameters:
- WIDTH, 8, radicand/root/remainder width; even, >= 4.
- DEPTH, 4, input FIFO entries; power of 2, >= 2.
- ITER, WIDTH/2, core iteration count; sets the watchdog limit. Not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  radicand offered
- in_ready  out  1  FIFO can accept
- in_rad  in  WIDTH  radicand
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_rad  out  WIDTH  radicand echoed with its result
- out_root  out  WIDTH  floor(sqrt(out_rad))
- out_rem  out  WIDTH  out_rad - out_root^2
- core_start  out  1  one-cycle start to core
- core_rad  out  WIDTH  radicand to core
- core_busy  in  1  core busy
- core_valid  in  1  core result valid, held until next start
- core_root  in  WIDTH  core root
- core_rem  in  WIDTH  core remainder
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky watchdog error

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and level = 0.
  - state = IDLE.
  - out_valid = 0; out_rad, out_root, out_rem = 0.
  - core_start = 0, core_rad = 0, err = 0.
  - The core has no reset. An operation in flight at reset is abandoned; the next start overrides it.
- Input FIFO:
  - in_ready = (level != DEPTH), decoded from registers only.
  - Push on in_valid && in_ready.
  - Pop only on an issue event.
  - Simultaneous push and pop: level is unchanged.
  - No push while full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: if level != 0, pop the head into core_rad, set core_start = 1, go to ISSUE.
  - ISSUE: core_start = 0 at the next edge (exactly one cycle high); go to WAIT_DONE unconditionally.
    - core_busy/core_valid are never sampled outside WAIT_DONE, so stale or X core state is ignored.
  - WAIT_DONE: done = !core_busy && core_valid.
    - When done and the output slot is free (!out_valid, or out_ready this cycle):
      - capture out_rad = core_rad, out_root = core_root, out_rem = core_rem;
      - set out_valid = 1;
      - if level != 0, issue in the same edge (pop, core_start = 1, go to ISSUE); otherwise go to IDLE.
    - When done but the slot is full: stay in WAIT_DONE. The core holds its outputs because no start is issued.
- core_rad is held stable from issue until capture.
- Output: out_valid clears on out_ready unless a new capture happens in the same edge. Capture and drain in the same edge is legal and yields back-to-back out_valid.
- Latency and throughput:
  - Input accepted at edge E0 into an empty block:
    - core_start high after E1;
    - core samples start at E2;
    - out_valid high after E(ITER+3).
  - Sustained throughput with out_ready = 1: one result per ITER+2 cycles.
- Watchdog:
  - A counter clears on entering WAIT_DONE and increments each cycle in WAIT_DONE while not done.
  - Reaching ITER+4 sets err (sticky until reset). The FSM keeps waiting.
  - Stalls due to the output slot being full do not count.
- Ordering: results always leave in push order.

Test Plan:
- Single rad 200, out_ready = 1 → exactly one core_start pulse; out_valid high after E7 (WIDTH = 8); out_rad = 200, root = 14, rem = 4; err = 0.
- Burst 0, 255, 144, 1 with out_ready = 1 → results in order: (0,0,0), (255,15,30), (144,12,0), (1,1,0); results 6 cycles apart; level peaks and returns to 0.
- Push 6 while out_ready = 0 → in_ready drops when level = 4. The first result sits in the slot while the second is held in the core (WAIT_DONE); no extra core_start. Release out_ready → all accepted items drain in order with correct values.
- Simultaneous push and pop at level = 2 → level stays 2. At level = 4, in_valid held with an issue the same cycle → no push, level becomes 3.
- rst_n asserted mid-operation (WAIT_DONE, FIFO holding 2) → outputs immediately at reset values. After release, push rad 99 → result (99, 9, 18); no stale result emitted.
- Core model holds core_busy = 1 forever → err set exactly ITER+4 cycles after entering WAIT_DONE and stays 1; in_ready follows level.
